// File: rtl/ov7670_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ov7670_capture : OV7670 byte stream -> RGB565 FIFO words with SOF tokens   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module ov7670_capture #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter bit BYTE_ORDER   = 1'b0
) (
  input  logic        cam_clk,
  input  logic        reset_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        enable,
  input  logic        clear_status,
  input  logic        fifo_full,
  output logic [16:0] fifo_data,
  output logic        fifo_wr_en,
  output logic [15:0] frame_count,
  output logic        overflow,
  output logic        frame_error
);

  localparam int PIX_W = $clog2(FRAME_WIDTH + 2);
  localparam int LIN_W = $clog2(FRAME_HEIGHT + 2);

  // Counters saturate one past nominal so an over-long line/frame never wraps back to "valid"
  localparam logic [PIX_W-1:0] c_frame_w = PIX_W'(FRAME_WIDTH);
  localparam logic [PIX_W-1:0] c_pix_sat = PIX_W'(FRAME_WIDTH + 1);
  localparam logic [LIN_W-1:0] c_frame_h = LIN_W'(FRAME_HEIGHT);
  localparam logic [LIN_W-1:0] c_lin_sat = LIN_W'(FRAME_HEIGHT + 1);
  localparam logic [16:0]      c_sof_tok = 17'h10000;

  localparam logic [2:0] c_st_wait  = 3'd0;
  localparam logic [2:0] c_st_armed = 3'd1;
  localparam logic [2:0] c_st_sof   = 3'd2;
  localparam logic [2:0] c_st_frame = 3'd3;
  localparam logic [2:0] c_st_drop  = 3'd4;

  logic [2:0]       r_state;
  logic             r_vsync_q, r_href_q, r_vsync_d, r_href_d;
  logic [7:0]       r_data_q, r_byte_a;
  logic             r_phase, r_frame_bad;
  logic [PIX_W-1:0] r_pix_cnt;
  logic [LIN_W-1:0] r_lin_cnt;

  logic        w_vs_rise, w_vs_fall, w_href_fall;
  logic        w_in_frame, w_byte_ev, w_px_ev, w_px_in_range, w_line_end;
  logic        w_ovf_evt, w_err_evt;
  logic [15:0] w_pixel;

  assign w_vs_rise   = r_vsync_q & ~r_vsync_d;
  assign w_vs_fall   = ~r_vsync_q & r_vsync_d;
  assign w_href_fall = ~r_href_q & r_href_d;

  assign w_in_frame    = (r_state == c_st_frame) & ~w_vs_rise;
  assign w_byte_ev     = w_in_frame & r_href_q & ~r_vsync_q;
  assign w_px_ev       = w_byte_ev & r_phase;
  assign w_px_in_range = (r_pix_cnt < c_frame_w) & (r_lin_cnt < c_frame_h);
  assign w_line_end    = w_in_frame & w_href_fall;
  assign w_pixel       = BYTE_ORDER ? {r_data_q, r_byte_a} : {r_byte_a, r_data_q};

  assign w_ovf_evt = ((r_state == c_st_armed) & w_vs_fall & enable & fifo_full)
                   | (w_px_ev & w_px_in_range & fifo_full);
  assign w_err_evt = (w_px_ev & ~w_px_in_range)
                   | (w_line_end & ((r_pix_cnt != c_frame_w) | r_phase))
                   | ((r_state == c_st_frame) & w_vs_rise & (r_lin_cnt != c_frame_h));

  always_ff @(posedge cam_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= c_st_wait;
      r_vsync_q   <= 1'b0;
      r_href_q    <= 1'b0;
      r_vsync_d   <= 1'b0;
      r_href_d    <= 1'b0;
      r_data_q    <= 8'h00;
      r_byte_a    <= 8'h00;
      r_phase     <= 1'b0;
      r_frame_bad <= 1'b0;
      r_pix_cnt   <= '0;
      r_lin_cnt   <= '0;
      fifo_data   <= 17'h00000;
      fifo_wr_en  <= 1'b0;
      frame_count <= 16'h0000;
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      r_vsync_q  <= cam_vsync;
      r_href_q   <= cam_href;
      r_data_q   <= cam_data;
      r_vsync_d  <= r_vsync_q;
      r_href_d   <= r_href_q;
      fifo_wr_en <= 1'b0;
      if (w_err_evt) r_frame_bad <= 1'b1;

      case (r_state)
        c_st_wait: if (w_vs_rise) r_state <= c_st_armed;
        c_st_armed: begin
          if (w_vs_fall && enable && !fifo_full) begin
            r_state     <= c_st_sof;
            fifo_wr_en  <= 1'b1;
            fifo_data   <= c_sof_tok;
            r_pix_cnt   <= '0;
            r_lin_cnt   <= '0;
            r_phase     <= 1'b0;
            r_frame_bad <= 1'b0;
          end
        end
        c_st_sof: r_state <= c_st_frame;
        c_st_frame: begin
          if (w_vs_rise) begin
            r_state <= c_st_armed;
            if (r_lin_cnt == c_frame_h && !r_frame_bad) frame_count <= frame_count + 16'd1;
          end else if (w_byte_ev) begin
            if (!r_phase) begin
              r_byte_a <= r_data_q;
              r_phase  <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              if (r_pix_cnt != c_pix_sat) r_pix_cnt <= r_pix_cnt + PIX_W'(1);
              if (w_px_in_range) begin
                if (fifo_full) begin
                  r_state <= c_st_drop;
                end else begin
                  fifo_wr_en <= 1'b1;
                  fifo_data  <= {1'b0, w_pixel};
                end
              end
            end
          end else if (w_line_end) begin
            r_phase   <= 1'b0;
            r_pix_cnt <= '0;
            if (r_lin_cnt != c_lin_sat) r_lin_cnt <= r_lin_cnt + LIN_W'(1);
          end
        end
        c_st_drop: if (w_vs_rise) r_state <= c_st_armed;
        default: r_state <= c_st_wait;
      endcase

      // A new event in the same cycle as clear_status keeps the flag set
      overflow    <= w_ovf_evt | (overflow & ~clear_status);
      frame_error <= w_err_evt | (frame_error & ~clear_status);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ov7670_capture.sv
`default_nettype none
// Directed bench for ov7670_capture (FRAME_WIDTH=4, FRAME_HEIGHT=2), one DUT per byte order.
module tb_ov7670_capture;

  logic        cam_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        enable = 1'b1;
  logic        clear_status = 1'b0;
  logic        fifo_full = 1'b0;

  logic [16:0] fifo_data0, fifo_data1;
  logic        fifo_wr_en0, fifo_wr_en1;
  logic [15:0] frame_count0, frame_count1;
  logic        overflow0, overflow1, frame_error0, frame_error1;

  int errors = 0;
  int checks = 0;
  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [16:0] line_px[4];

  always #5 cam_clk = ~cam_clk;

  ov7670_capture #(.FRAME_WIDTH(4), .FRAME_HEIGHT(2), .BYTE_ORDER(1'b0)) u_dut0 (
    .cam_clk(cam_clk), .reset_n(reset_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .enable(enable), .clear_status(clear_status), .fifo_full(fifo_full),
    .fifo_data(fifo_data0), .fifo_wr_en(fifo_wr_en0), .frame_count(frame_count0),
    .overflow(overflow0), .frame_error(frame_error0)
  );

  ov7670_capture #(.FRAME_WIDTH(4), .FRAME_HEIGHT(2), .BYTE_ORDER(1'b1)) u_dut1 (
    .cam_clk(cam_clk), .reset_n(reset_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .enable(enable), .clear_status(clear_status), .fifo_full(fifo_full),
    .fifo_data(fifo_data1), .fifo_wr_en(fifo_wr_en1), .frame_count(frame_count1),
    .overflow(overflow1), .frame_error(frame_error1)
  );

  always @(negedge cam_clk) begin
    if (fifo_wr_en0) q0.push_back(fifo_data0);
    if (fifo_wr_en1) q1.push_back(fifo_data1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge cam_clk);
      #1;
    end
  endtask

  task automatic vs_rise();
    cam_vsync = 1'b1;
    step(4);
  endtask

  task automatic vs_fall();
    cam_vsync = 1'b0;
    step(4);
  endtask

  // Bytes 1..nbytes; fifo_full is raised together with byte index full_at
  task automatic send_line(input int nbytes, input int full_at);
    cam_href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      cam_data = 8'(i + 1);
      if (i == full_at) fifo_full = 1'b1;
      step(1);
    end
    cam_href = 1'b0;
    cam_data = 8'h00;
    step(4);
  endtask

  task automatic clear_queues();
    q0.delete();
    q1.delete();
  endtask

  task automatic check_clean_frame(input string tag);
    check_eq({tag, "_len"}, q0.size(), 9);
    if (q0.size() == 9) begin
      check_eq({tag, "_sof"}, q0[0], 17'h10000);
      for (int i = 1; i < 9; i++)
        check_eq($sformatf("%s_w%0d", tag, i), q0[i], line_px[(i - 1) % 4]);
    end
  endtask

  initial begin
    line_px[0] = 17'h00102;
    line_px[1] = 17'h00304;
    line_px[2] = 17'h00506;
    line_px[3] = 17'h00708;

    // Reset state
    step(3);
    reset_n = 1'b1;
    step(1);
    check_eq("rst_wr_en", fifo_wr_en0, 0);
    check_eq("rst_data", fifo_data0, 0);
    check_eq("rst_count", frame_count0, 0);
    check_eq("rst_ovf", overflow0, 0);
    check_eq("rst_err", frame_error0, 0);

    // Clean frame, both byte orders
    vs_rise();
    vs_fall();
    send_line(8, -1);
    send_line(8, -1);
    vs_rise();
    check_clean_frame("t1");
    check_eq("t1_count", frame_count0, 1);
    check_eq("t1_ovf", overflow0, 0);
    check_eq("t1_err", frame_error0, 0);
    check_eq("t2_len", q1.size(), 9);
    if (q1.size() >= 3) begin
      check_eq("t2_sof", q1[0], 17'h10000);
      check_eq("t2_px0", q1[1], 17'h00201);
      check_eq("t2_px1", q1[2], 17'h00403);
    end
    clear_queues();

    // Reset in the middle of line 1
    vs_fall();
    cam_href = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cam_data = 8'(i + 1);
      step(1);
    end
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    clear_queues();
    check_eq("t3_rst_count", frame_count0, 0);
    for (int i = 4; i < 8; i++) begin
      cam_data = 8'(i + 1);
      step(1);
    end
    cam_href = 1'b0;
    step(4);
    send_line(8, -1);
    check_eq("t3_silent", q0.size(), 0);
    vs_rise();
    vs_fall();
    send_line(8, -1);
    send_line(8, -1);
    vs_rise();
    check_clean_frame("t3");
    check_eq("t3_count", frame_count0, 1);
    clear_queues();

    // FIFO full on the third pixel of the frame
    vs_fall();
    send_line(8, 5);
    fifo_full = 1'b0;
    send_line(8, -1);
    vs_rise();
    check_eq("t4_len", q0.size(), 3);
    if (q0.size() == 3) begin
      check_eq("t4_sof", q0[0], 17'h10000);
      check_eq("t4_px0", q0[1], 17'h00102);
      check_eq("t4_px1", q0[2], 17'h00304);
    end
    check_eq("t4_ovf", overflow0, 1);
    check_eq("t4_count", frame_count0, 1);
    clear_queues();
    vs_fall();
    send_line(8, -1);
    send_line(8, -1);
    vs_rise();
    check_clean_frame("t4b");
    check_eq("t4b_count", frame_count0, 2);
    check_eq("t4b_ovf_sticky", overflow0, 1);
    clear_status = 1'b1;
    step(1);
    clear_status = 1'b0;
    step(1);
    check_eq("t4_ovf_clr", overflow0, 0);
    clear_queues();

    // Short line
    vs_fall();
    send_line(6, -1);
    send_line(8, -1);
    vs_rise();
    check_eq("t5_err", frame_error0, 1);
    check_eq("t5_count", frame_count0, 2);
    check_eq("t5_len", q0.size(), 8);
    clear_status = 1'b1;
    step(1);
    clear_status = 1'b0;
    step(1);
    check_eq("t5_err_clr", frame_error0, 0);
    clear_queues();

    // Enable low at frame start, raised mid-frame
    enable = 1'b0;
    vs_fall();
    send_line(8, -1);
    enable = 1'b1;
    send_line(8, -1);
    vs_rise();
    check_eq("t6_silent", q0.size(), 0);
    check_eq("t6_count", frame_count0, 2);
    vs_fall();
    send_line(8, -1);
    send_line(8, -1);
    vs_rise();
    check_clean_frame("t6b");
    check_eq("t6b_count", frame_count0, 3);
    check_eq("t6b_err", frame_error0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
